// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer: accepts bit-reversed-order FFT samples and
// emits them in natural order through a ping-pong pair of frame banks
// with a registered, back-pressurable output stage.
module fft_out_reorder #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [FLOAT_PRECISION-1:0] di_re,
  input  logic [FLOAT_PRECISION-1:0] di_im,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [FLOAT_PRECISION-1:0] do_re,
  output logic [FLOAT_PRECISION-1:0] do_im,
  output logic                       overflow
);

  localparam int N = 1 << logn;
  localparam logic [logn-1:0] CNT_LAST = '1;

  // Frame storage, two banks; contents are deliberately not reset.
  logic [FLOAT_PRECISION-1:0] bank_re [2][N];
  logic [FLOAT_PRECISION-1:0] bank_im [2][N];

  logic [logn-1:0] wcnt;
  logic [logn-1:0] rcnt;
  logic [logn-1:0] wr_addr;
  logic            wb;
  logic            rb;
  logic [1:0]      full;
  logic [1:0]      full_nxt;

  logic            we;
  logic            wr_done;
  logic            ld;
  logic            rd_done;
  logic [FLOAT_PRECISION-1:0] rd_re;
  logic [FLOAT_PRECISION-1:0] rd_im;

  // Writes only target a non-full bank and reads only a full one, so the
  // two sides never touch the same bank on the same edge.
  assign we      = in_valid & ~full[wb];
  assign wr_done = we & (wcnt == CNT_LAST);
  assign ld      = full[rb] & (~out_valid | out_ready);
  assign rd_done = ld & (rcnt == CNT_LAST);
  assign wr_addr = {<<{wcnt}};
  assign rd_re   = bank_re[rb][rcnt];
  assign rd_im   = bank_im[rb][rcnt];

  // Store each accepted sample at its bit-reversed address.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      bank_re[wb][wr_addr] <= di_re;
      bank_im[wb][wr_addr] <= di_im;
    end
  end

  // Write counter, write bank select and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt     <= '0;
      wb       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (we) begin
        wcnt <= wcnt + logn'(1);
        if (wr_done) wb <= ~wb;
      end
      if (in_valid && full[wb]) overflow <= 1'b1;
    end
  end

  // Next full flags: set on frame completion, clear on frame drain; the
  // set and clear always address different banks.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wb] = 1'b1;
    if (rd_done) full_nxt[rb] = 1'b0;
  end

  // Full flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) full <= '0;
    else        full <= full_nxt;
  end

  // Read counter, read bank select and output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt      <= '0;
      rb        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
    end else if (ld) begin
      do_re     <= rd_re;
      do_im     <= rd_im;
      out_valid <= 1'b1;
      out_last  <= (rcnt == CNT_LAST);
      rcnt      <= rcnt + logn'(1);
      if (rd_done) rb <= ~rb;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder with logn=3 (N=8).
module tb_fft_out_reorder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] di_re;
  logic [63:0] di_im;
  logic        out_ready;
  logic        out_valid;
  logic        out_last;
  logic [63:0] do_re;
  logic [63:0] do_im;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Natural-order output k carries input sample bitrev3(k).
  int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [63:0] q_re [$];
  logic [63:0] q_im [$];
  bit          q_last [$];
  int          q_cyc [$];

  fft_out_reorder #(.FLOAT_PRECISION(64), .logn(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .di_re(di_re), .di_im(di_im),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .do_re(do_re), .do_im(do_im), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every handshake that will complete on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      q_re.push_back(do_re);
      q_im.push_back(do_im);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_re.delete();
    q_im.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  // Drive one frame (re = base+k, im = 100+base+k); leaves in_valid high.
  task automatic send_frame(input int base);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      di_re    = 64'(base + k);
      di_im    = 64'(100 + base + k);
      tick();
    end
  endtask

  task automatic wait_outputs(input int n);
    for (int i = 0; i < 80 && q_re.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; di_re = '0; di_im = '0;
    tick(); tick();
    rst_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      fails++; $display("FAIL reset_flags valid=%b last=%b exp 0 0", out_valid, out_last);
    end
    tests++;
    if (do_re !== 64'd0 || do_im !== 64'd0) begin
      fails++; $display("FAIL reset_data re=%0d im=%0d exp 0 0", do_re, do_im);
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL reset_overflow got=%b exp 0", overflow);
    end
  endtask

  task automatic test_single_frame();
    clear_q();
    out_ready = 1'b1;
    send_frame(0);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_latency_early valid=%b exp 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || do_re !== 64'd0 || do_im !== 64'd100) begin
      fails++; $display("FAIL single_latency valid=%b re=%0d im=%0d exp 1 0 100", out_valid, do_re, do_im);
    end
    wait_outputs(8);
    tests++;
    if (q_re.size() != 8) begin
      fails++; $display("FAIL single_count got=%0d exp 8", q_re.size());
    end
    for (int j = 0; j < 8 && j < q_re.size(); j++) begin
      tests++;
      if (q_re[j] !== 64'(rev[j]) || q_im[j] !== 64'(100 + rev[j]) || q_last[j] !== (j == 7)) begin
        fails++;
        $display("FAIL single_out%0d re=%0d im=%0d last=%0b exp re=%0d im=%0d last=%0b",
                 j, q_re[j], q_im[j], q_last[j], rev[j], 100 + rev[j], j == 7);
      end
    end
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      fails++; $display("FAIL single_idle valid=%b last=%b exp 0 0", out_valid, out_last);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    out_ready = 1'b1;
    send_frame(0);
    send_frame(8);
    in_valid = 1'b0;
    wait_outputs(16);
    tests++;
    if (q_re.size() != 16) begin
      fails++; $display("FAIL b2b_count got=%0d exp 16", q_re.size());
    end
    for (int j = 0; j < 16 && j < q_re.size(); j++) begin
      tests++;
      if (q_re[j] !== 64'(8 * (j / 8) + rev[j % 8]) || q_im[j] !== 64'(100 + 8 * (j / 8) + rev[j % 8]) ||
          q_last[j] !== ((j % 8) == 7)) begin
        fails++;
        $display("FAIL b2b_out%0d re=%0d im=%0d last=%0b exp re=%0d last=%0b",
                 j, q_re[j], q_im[j], q_last[j], 8 * (j / 8) + rev[j % 8], (j % 8) == 7);
      end
    end
    for (int j = 1; j < q_cyc.size(); j++) begin
      tests++;
      if (q_cyc[j] != q_cyc[0] + j) begin
        fails++; $display("FAIL b2b_gap%0d cycle=%0d exp %0d", j, q_cyc[j], q_cyc[0] + j);
      end
    end
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL b2b_overflow got=%b exp 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b1;
    send_frame(16);
    in_valid = 1'b0;
    tick(); tick(); tick();
    // Output index 2 (input sample 2) is now on the register.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (do_re !== 64'd18 || do_im !== 64'd118 || out_valid !== 1'b1 || out_last !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d re=%0d im=%0d valid=%b last=%b exp 18 118 1 0",
                 c, do_re, do_im, out_valid, out_last);
      end
    end
    out_ready = 1'b1;
    wait_outputs(8);
    tick(); tick(); tick();
    tests++;
    if (q_re.size() != 8) begin
      fails++; $display("FAIL bp_count got=%0d exp 8", q_re.size());
    end
    for (int j = 0; j < 8 && j < q_re.size(); j++) begin
      tests++;
      if (q_re[j] !== 64'(16 + rev[j]) || q_im[j] !== 64'(116 + rev[j]) || q_last[j] !== (j == 7)) begin
        fails++;
        $display("FAIL bp_out%0d re=%0d im=%0d last=%0b exp re=%0d last=%0b",
                 j, q_re[j], q_im[j], q_last[j], 16 + rev[j], j == 7);
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        in_valid = 1'b1;
        di_re    = 64'(8 * f + k);
        di_im    = 64'(100 + 8 * f + k);
        tick();
        if (f == 1 && k == 7) begin
          tests++;
          if (overflow !== 1'b0) begin
            fails++; $display("FAIL ovf_before got=%b exp 0", overflow);
          end
        end
        if (f == 2 && k == 0) begin
          tests++;
          if (overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_first_drop got=%b exp 1", overflow);
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_outputs(16);
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (q_re.size() != 16) begin
      fails++; $display("FAIL ovf_count got=%0d exp 16", q_re.size());
    end
    for (int j = 0; j < 16 && j < q_re.size(); j++) begin
      tests++;
      if (q_re[j] !== 64'(8 * (j / 8) + rev[j % 8]) || q_im[j] !== 64'(100 + 8 * (j / 8) + rev[j % 8]) ||
          q_last[j] !== ((j % 8) == 7)) begin
        fails++;
        $display("FAIL ovf_out%0d re=%0d im=%0d last=%0b exp re=%0d last=%0b",
                 j, q_re[j], q_im[j], q_last[j], 8 * (j / 8) + rev[j % 8], (j % 8) == 7);
      end
    end
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky got=%b exp 1", overflow);
    end
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      di_re    = 64'(40 + k);
      di_im    = 64'(140 + k);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || do_re !== 64'd0 || do_im !== 64'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL midrst_state valid=%b last=%b re=%0d im=%0d ovf=%b exp 0 0 0 0 0",
               out_valid, out_last, do_re, do_im, overflow);
    end
    clear_q();
    send_frame(24);
    in_valid = 1'b0;
    wait_outputs(8);
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (q_re.size() != 8) begin
      fails++; $display("FAIL midrst_count got=%0d exp 8", q_re.size());
    end
    for (int j = 0; j < 8 && j < q_re.size(); j++) begin
      tests++;
      if (q_re[j] !== 64'(24 + rev[j]) || q_im[j] !== 64'(124 + rev[j]) || q_last[j] !== (j == 7)) begin
        fails++;
        $display("FAIL midrst_out%0d re=%0d im=%0d last=%0b exp re=%0d last=%0b",
                 j, q_re[j], q_im[j], q_last[j], 24 + rev[j], j == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
